// File: rtl/mem_sched_pkg.sv
// ---------------------------------------------------------------------------
// mem_sched_pkg
//   Shared types for the data-memory request scheduler.
//   - sched_state_e : scheduler FSM states
//   - SZ_*          : bus access size encodings
// ---------------------------------------------------------------------------
package mem_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,   // nothing outstanding, waiting for E ops
        ST_WAIT1  = 3'd1,   // slot1 accepted, waiting for its response
        ST_ISSUE2 = 3'd2,   // slot2 pending, bus idle
        ST_WAIT2  = 3'd3,   // slot2 accepted, waiting for its response
        ST_DONE   = 3'd4,   // one-cycle release of the pipeline
        ST_DRAIN  = 3'd5    // killed op still outstanding on the bus
    } sched_state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem_sched_perf.sv
// ---------------------------------------------------------------------------
// mem_sched_perf
//   Performance counters for mem_req_sched (built only when
//   MEM_SCHED_PERF_CNT_EN is defined). Both counters wrap at 2^32.
//   Ports:
//     clk, rst        clock, synchronous active-low reset
//     dual_done       pulse: a dual-op pair left WAIT2
//     stall_req       scheduler stall request
//     perf_dual_cnt   number of dual-op completions
//     perf_stall_cnt  number of cycles with stall_req=1
// ---------------------------------------------------------------------------
module mem_sched_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        dual_done,
    input  logic        stall_req,
    output logic [31:0] perf_dual_cnt,
    output logic [31:0] perf_stall_cnt
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_dual_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (dual_done) perf_dual_cnt  <= perf_dual_cnt + 32'd1;
            if (stall_req) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/mem_req_sched.sv
// ---------------------------------------------------------------------------
// mem_req_sched
//   Serializes the memory ops of both E-stage issue slots onto a single
//   SRAM-like data bus (req/addr_ok/data_ok), slot1 (older) first, with at
//   most one transaction outstanding. Stalls the pipeline until all ops of
//   the current pair complete, then releases it for exactly one cycle (DONE)
//   so the same ops are never issued twice. Load read data is captured per
//   slot for M-stage extraction.
//
//   Optional: define MEM_SCHED_PERF_CNT_EN to add perf_dual_cnt and
//   perf_stall_cnt outputs (see mem_sched_perf).
//
//   Ports:
//     clk, rst                 clock, synchronous active-low reset
//     mem_v*E/mem_wr*E/size*E  per-slot op valid, store flag, access size
//     addr*E/wdata*E/wstrb*E   per-slot address, aligned data, byte enables
//     kill                     flush: abandon the current ops
//     data_*                   data bus master interface
//     rdata1M, rdata2M         captured load data per slot
//     stall_req                freeze the pipeline from E backwards
// ---------------------------------------------------------------------------
module mem_req_sched
    import mem_sched_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_v1E,
    input  logic              mem_v2E,
    input  logic              mem_wr1E,
    input  logic              mem_wr2E,
    input  logic [1:0]        size1E,
    input  logic [1:0]        size2E,
    input  logic [ADDR_W-1:0] addr1E,
    input  logic [ADDR_W-1:0] addr2E,
    input  logic [DATA_W-1:0] wdata1E,
    input  logic [DATA_W-1:0] wdata2E,
    input  logic [3:0]        wstrb1E,
    input  logic [3:0]        wstrb2E,
    input  logic              kill,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    output logic [3:0]        data_wstrb,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic [DATA_W-1:0] rdata1M,
    output logic [DATA_W-1:0] rdata2M,
    output logic              stall_req
`ifdef MEM_SCHED_PERF_CNT_EN
    ,
    output logic [31:0]       perf_dual_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    sched_state_e state, state_nxt;
    logic         any_v;
    logic         sel2;     // bus payload comes from slot2

    assign any_v = mem_v1E | mem_v2E;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic. kill always wins over issuing; a kill that meets the
    // response in the same cycle simply discards it.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!kill && any_v && data_addr_ok)
                    state_nxt = mem_v1E ? ST_WAIT1 : ST_WAIT2;
            end
            ST_WAIT1: begin
                if (kill)              state_nxt = data_data_ok ? ST_IDLE : ST_DRAIN;
                else if (data_data_ok) state_nxt = mem_v2E ? ST_ISSUE2 : ST_DONE;
            end
            ST_ISSUE2: begin
                if (kill)              state_nxt = ST_IDLE;
                else if (data_addr_ok) state_nxt = ST_WAIT2;
            end
            ST_WAIT2: begin
                if (kill)              state_nxt = data_data_ok ? ST_IDLE : ST_DRAIN;
                else if (data_data_ok) state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            ST_DRAIN: begin
                if (data_data_ok) state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: request/select and stall
    always_comb begin
        data_req  = 1'b0;
        sel2      = 1'b0;
        stall_req = 1'b0;
        case (state)
            ST_IDLE: begin
                data_req  = any_v & ~kill;
                sel2      = ~mem_v1E;
                stall_req = any_v & ~kill;
            end
            ST_WAIT1, ST_WAIT2: begin
                stall_req = ~kill;
            end
            ST_ISSUE2: begin
                data_req  = ~kill;
                sel2      = 1'b1;
                stall_req = ~kill;
            end
            // DRAIN only stalls if new ops are already waiting in E
            ST_DRAIN: stall_req = any_v & ~kill;
            default: ;
        endcase
    end

    // Bus payload, forced to zero while no request is driven
    always_comb begin
        data_wr    = 1'b0;
        data_size  = '0;
        data_addr  = '0;
        data_wdata = '0;
        data_wstrb = '0;
        if (data_req) begin
            if (sel2) begin
                data_wr    = mem_wr2E;
                data_size  = size2E;
                data_addr  = addr2E;
                data_wdata = wdata2E;
                data_wstrb = wstrb2E;
            end else begin
                data_wr    = mem_wr1E;
                data_size  = size1E;
                data_addr  = addr1E;
                data_wdata = wdata1E;
                data_wstrb = wstrb1E;
            end
        end
    end

    // Read data capture. The E fields are held while an op is outstanding,
    // so mem_wr*E still describes the op whose response is arriving.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata1M <= '0;
            rdata2M <= '0;
        end else if (data_data_ok && !kill) begin
            if (state == ST_WAIT1 && !mem_wr1E) rdata1M <= data_rdata;
            if (state == ST_WAIT2 && !mem_wr2E) rdata2M <= data_rdata;
        end
    end

`ifdef MEM_SCHED_PERF_CNT_EN
    // Remembers whether the op in WAIT2 came through ISSUE2 (a real pair)
    // rather than being a slot2-only op issued from IDLE.
    logic dual_f;
    logic dual_done;

    always_ff @(posedge clk) begin
        if (!rst)
            dual_f <= 1'b0;
        else if (state == ST_ISSUE2 && state_nxt == ST_WAIT2)
            dual_f <= 1'b1;
        else if (state == ST_IDLE && state_nxt == ST_WAIT2)
            dual_f <= 1'b0;
    end

    assign dual_done = (state == ST_WAIT2) && (state_nxt != ST_WAIT2) && dual_f;

    mem_sched_perf u_perf (
        .clk            (clk),
        .rst            (rst),
        .dual_done      (dual_done),
        .stall_req      (stall_req),
        .perf_dual_cnt  (perf_dual_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_mem_req_sched.sv
module tb_mem_req_sched;

    typedef struct packed {
        logic        v;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } op_t;

    typedef struct packed {
        logic slot2;
        op_t  op;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_v1E = 0, mem_v2E = 0, mem_wr1E = 0, mem_wr2E = 0;
    logic [1:0]  size1E = 0, size2E = 0;
    logic [31:0] addr1E = 0, addr2E = 0, wdata1E = 0, wdata2E = 0;
    logic [3:0]  wstrb1E = 0, wstrb2E = 0;
    logic        kill = 0;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] rdata1M, rdata2M;
    logic        stall_req;
`ifdef MEM_SCHED_PERF_CNT_EN
    logic [31:0] perf_dual_cnt, perf_stall_cnt;
`endif

    mem_req_sched #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .mem_v1E(mem_v1E), .mem_v2E(mem_v2E),
        .mem_wr1E(mem_wr1E), .mem_wr2E(mem_wr2E),
        .size1E(size1E), .size2E(size2E),
        .addr1E(addr1E), .addr2E(addr2E),
        .wdata1E(wdata1E), .wdata2E(wdata2E),
        .wstrb1E(wstrb1E), .wstrb2E(wstrb2E),
        .kill(kill),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .rdata1M(rdata1M), .rdata2M(rdata2M),
        .stall_req(stall_req)
`ifdef MEM_SCHED_PERF_CNT_EN
        , .perf_dual_cnt(perf_dual_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errs = 0, checks = 0;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errs++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- bus responder ----------------
    int ok_cfg = 0, dok_cfg = 0;        // -1 = random latency
    bit rdata_cfg_en = 1'b1;
    logic [31:0] rdata_cfg = 32'h0;
    int req_cnt = 0, ok_lat = 0, dok_lat = 0, dcnt = 0;
    bit pend = 1'b0;

    initial begin
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = '0;
        forever begin
            @(negedge clk);
            if (req_cnt == 0) ok_lat = (ok_cfg >= 0) ? ok_cfg : int'($urandom_range(0, 3));
            data_addr_ok = (req_cnt >= ok_lat);
            data_data_ok = pend && (dcnt >= dok_lat);
            data_rdata   = rdata_cfg_en ? rdata_cfg : $urandom;
            if (data_data_ok) pend = 1'b0;
            else if (pend)    dcnt++;
            #1;
            if (data_req && data_addr_ok) begin
                pend    = 1'b1;
                dcnt    = 0;
                dok_lat = (dok_cfg >= 0) ? dok_cfg : int'($urandom_range(0, 3));
                req_cnt = 0;
            end else if (data_req) req_cnt++;
            else req_cnt = 0;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    exp_t        expq[$];
    bit          mon_en = 1'b0;
    logic [31:0] mdl_r1 = '0, mdl_r2 = '0;
    bit          out_valid = 0, out_slot2 = 0, out_load = 0, out_killed = 0;
    bit          prev_bp = 0;
    logic [70:0] prev_pl = '0;
    int          hs_cnt = 0, req_cyc = 0, req_cyc_last = 0, stall_run = 0, last_run = 0;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                logic  exp_stall;
                exp_t  e;
                logic [70:0] pl;
                pl = {data_wr, data_size, data_addr, data_wdata, data_wstrb};
                chk(rdata1M === mdl_r1, "rdata1M", rdata1M, mdl_r1);
                chk(rdata2M === mdl_r2, "rdata2M", rdata2M, mdl_r2);
                if (kill) begin
                    expq.delete();
                    if (out_valid) out_killed = 1'b1;
                end
                exp_stall = !kill && (expq.size() != 0 || (out_valid && !out_killed));
                chk(stall_req === exp_stall, "stall_req", {31'd0, stall_req}, {31'd0, exp_stall});
                if (kill || out_valid)
                    chk(data_req === 1'b0, "req_blocked", {31'd0, data_req}, 32'd0);
                if (prev_bp && !kill)
                    chk(data_req === 1'b1 && pl === prev_pl, "bp_stable", data_addr, prev_pl[67:36]);
                if (data_data_ok && out_valid) begin
                    if (!out_killed && out_load) begin
                        if (out_slot2) mdl_r2 = data_rdata;
                        else           mdl_r1 = data_rdata;
                    end
                    out_valid = 1'b0;
                end
                if (data_req) begin
                    if (data_addr_ok) begin
                        if (expq.size() == 0) begin
                            chk(1'b0, "unexpected_req", data_addr, 32'd0);
                            e = '0;
                        end else begin
                            e = expq.pop_front();
                            chk(data_wr === e.op.wr && data_size === e.op.size &&
                                data_addr === e.op.addr && data_wdata === e.op.wdata &&
                                data_wstrb === e.op.wstrb, "req_payload", data_addr, e.op.addr);
                        end
                        out_valid    = 1'b1;
                        out_slot2    = e.slot2;
                        out_load     = !e.op.wr;
                        out_killed   = 1'b0;
                        hs_cnt++;
                        req_cyc_last = req_cyc + 1;
                        req_cyc      = 0;
                    end else req_cyc++;
                end else begin
                    chk(pl === '0, "idle_payload", data_addr, 32'd0);
                end
                prev_bp = data_req && !data_addr_ok;
                prev_pl = pl;
                if (stall_req) stall_run++;
                else begin
                    if (stall_run > 0) last_run = stall_run;
                    stall_run = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic op_t mk(bit v, bit wr, logic [1:0] sz, logic [31:0] a,
                               logic [31:0] wd, logic [3:0] st);
        op_t o;
        o.v = v; o.wr = wr; o.size = sz; o.addr = a; o.wdata = wd; o.wstrb = st;
        return o;
    endfunction

    function automatic op_t rand_op();
        return mk($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  2'($urandom_range(0, 2)), $urandom, $urandom, 4'($urandom));
    endfunction

    task automatic load(input op_t o1, input op_t o2);
        mem_v1E = o1.v; mem_wr1E = o1.wr; size1E = o1.size; addr1E = o1.addr;
        wdata1E = o1.wdata; wstrb1E = o1.wstrb;
        mem_v2E = o2.v; mem_wr2E = o2.wr; size2E = o2.size; addr2E = o2.addr;
        wdata2E = o2.wdata; wstrb2E = o2.wstrb;
        if (o1.v) expq.push_back({1'b0, o1});
        if (o2.v) expq.push_back({1'b1, o2});
    endtask

    // Wait until the pipeline is released (stall_req low), bounded.
    task automatic wait_free();
        for (int c = 0; c < 200; c++) begin
            #3;
            if (!stall_req) return;
            @(negedge clk);
        end
        chk(1'b0, "stall_timeout", 32'd1, 32'd0);
    endtask

    localparam op_t NOP = '0;

    initial begin
        int hs0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk(data_req === 1'b0 && stall_req === 1'b0, "reset_outputs", {31'd0, data_req}, 32'd0);
        chk(rdata1M === 32'd0, "reset_rdata1M", rdata1M, 32'd0);
        chk(rdata2M === 32'd0, "reset_rdata2M", rdata2M, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;

        // single load, minimum latency
        ok_cfg = 0; dok_cfg = 0; rdata_cfg = 32'hDEADBEEF;
        hs0 = hs_cnt;
        @(negedge clk); load(mk(1, 0, 2'd2, 32'h100, 32'h0, 4'h0), NOP);
        wait_free();
        chk(last_run == 2, "single_stall_cycles", last_run, 2);
        chk(rdata1M === 32'hDEADBEEF, "single_rdata1M", rdata1M, 32'hDEADBEEF);
        chk(hs_cnt == hs0 + 1, "single_req_count", hs_cnt - hs0, 1);
        @(negedge clk); load(NOP, NOP);

        // dual: store then load
        rdata_cfg = 32'hCAFEF00D;
        hs0 = hs_cnt;
        @(negedge clk);
        load(mk(1, 1, 2'd2, 32'h200, 32'h11223344, 4'hF), mk(1, 0, 2'd2, 32'h204, 32'h0, 4'h0));
        wait_free();
        chk(last_run == 4, "dual_stall_cycles", last_run, 4);
        chk(rdata2M === 32'hCAFEF00D, "dual_rdata2M", rdata2M, 32'hCAFEF00D);
        chk(rdata1M === 32'hDEADBEEF, "dual_store_keeps_r1", rdata1M, 32'hDEADBEEF);
        chk(hs_cnt == hs0 + 2, "dual_req_count", hs_cnt - hs0, 2);
        @(negedge clk); load(NOP, NOP);

        // addr_ok backpressure for 3 cycles
        ok_cfg = 3;
        @(negedge clk); load(mk(1, 1, 2'd1, 32'h280, 32'h0000ABCD, 4'h3), NOP);
        wait_free();
        chk(req_cyc_last == 4, "bp_req_cycles", req_cyc_last, 4);
        chk(last_run == 5, "bp_stall_cycles", last_run, 5);
        @(negedge clk); load(NOP, NOP);

        // kill in WAIT1 of a dual op
        ok_cfg = 0; dok_cfg = 3; rdata_cfg = 32'h0BAD0BAD;
        hs0 = hs_cnt;
        @(negedge clk);
        load(mk(1, 0, 2'd2, 32'h400, 32'h0, 4'h0), mk(1, 0, 2'd2, 32'h404, 32'h0, 4'h0));
        for (int c = 0; c < 20; c++) begin
            #3;
            if (hs_cnt != hs0) break;
            @(negedge clk);
        end
        chk(hs_cnt == hs0 + 1, "kill_first_issue", hs_cnt - hs0, 1);
        @(negedge clk); kill = 1'b1;
        #3;
        chk(stall_req === 1'b0 && data_req === 1'b0, "kill_release", {31'd0, stall_req}, 32'd0);
        @(negedge clk); kill = 1'b0; load(NOP, NOP);
        repeat (8) @(negedge clk);
        #3;
        chk(rdata1M === 32'hDEADBEEF, "kill_discard_r1", rdata1M, 32'hDEADBEEF);
        chk(rdata2M === 32'hCAFEF00D, "kill_discard_r2", rdata2M, 32'hCAFEF00D);
        chk(hs_cnt == hs0 + 1, "kill_no_slot2", hs_cnt - hs0, 1);

        // kill before issue
        dok_cfg = 0;
        hs0 = hs_cnt;
        @(negedge clk); kill = 1'b1; load(mk(1, 0, 2'd0, 32'h500, 32'h0, 4'h0), NOP);
        #3;
        chk(data_req === 1'b0 && stall_req === 1'b0, "kill_idle", {31'd0, data_req}, 32'd0);
        @(negedge clk); kill = 1'b0; load(NOP, NOP);
        repeat (3) @(negedge clk);
        #3;
        chk(hs_cnt == hs0, "kill_idle_no_req", hs_cnt - hs0, 0);

        // slot2 only
        rdata_cfg = 32'h00300300;
        hs0 = hs_cnt;
        @(negedge clk); load(NOP, mk(1, 0, 2'd2, 32'h300, 32'h0, 4'h0));
        wait_free();
        chk(last_run == 2, "slot2_stall_cycles", last_run, 2);
        chk(rdata2M === 32'h00300300, "slot2_rdata2M", rdata2M, 32'h00300300);
        chk(rdata1M === 32'hDEADBEEF, "slot2_keeps_r1", rdata1M, 32'hDEADBEEF);
        chk(hs_cnt == hs0 + 1, "slot2_req_count", hs_cnt - hs0, 1);
        @(negedge clk); load(NOP, NOP);

        // randomized traffic with random kills and bus latencies
        ok_cfg = -1; dok_cfg = -1; rdata_cfg_en = 1'b0;
        for (int g = 0; g < 400; g++) begin
            bit freed;
            freed = 1'b0;
            @(negedge clk);
            kill = ($urandom_range(0, 19) == 0);
            load(rand_op(), rand_op());
            for (int c = 0; c < 200; c++) begin
                #3;
                if (!stall_req) begin freed = 1'b1; break; end
                @(negedge clk);
                kill = ($urandom_range(0, 14) == 0);
            end
            if (!freed) chk(1'b0, "rand_stall_timeout", 32'd1, 32'd0);
        end
        @(negedge clk); kill = 1'b0; load(NOP, NOP);
        repeat (10) @(negedge clk);
        chk(expq.size() == 0, "queue_drained", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
